// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage buffer: DEPTH-entry circular FIFO with valid/ready handshake and flush.
// Optional 32-bit downstream stall counter enabled by defining PIPE_BUF_STALL_CNT_EN.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 70,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
`ifdef PIPE_BUF_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_nxt;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic              in_ready_q, out_valid_q;
  logic              push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign push = in_valid_i & in_ready_q;
  assign pop  = out_valid_q & out_ready_i;

  // Next-state pointers and occupancy; flush clears state and drops any same-cycle push.
  always_comb begin
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    count_nxt  = count_q;
    if (flush_i) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_nxt = count_q + CNT_W'(1);
        2'b01:   count_nxt = count_q - CNT_W'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  // Handshake flags are registered from next occupancy: no ready/valid feed-through.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_nxt;
      rd_ptr_q    <= rd_ptr_nxt;
      count_q     <= count_nxt;
      in_ready_q  <= (count_nxt != CNT_W'(DEPTH));
      out_valid_q <= (count_nxt != '0);
      if (push && !flush_i) mem[wr_ptr_q] <= in_data_i;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = mem[rd_ptr_q];
  assign count_o     = count_q;

`ifdef PIPE_BUF_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles the head is held by downstream; survives flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: DEPTH=2 and DEPTH=3 instances, directed vectors.
// Stall counter checks are compiled in when PIPE_BUF_STALL_CNT_EN is defined.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic [DW-1:0] in_data2, out_data2;
  logic [1:0]    count2;
  logic          flush3, in_valid3, in_ready3, out_valid3, out_ready3;
  logic [DW-1:0] in_data3, out_data3;
  logic [1:0]    count3;
`ifdef PIPE_BUF_STALL_CNT_EN
  logic [31:0]   stall2, stall3;
`endif

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush_i(flush2),
    .in_valid_i(in_valid2), .in_data_i(in_data2), .in_ready_o(in_ready2),
    .out_valid_o(out_valid2), .out_data_o(out_data2), .out_ready_i(out_ready2),
`ifdef PIPE_BUF_STALL_CNT_EN
    .stall_cnt_o(stall2),
`endif
    .count_o(count2)
  );

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .flush_i(flush3),
    .in_valid_i(in_valid3), .in_data_i(in_data3), .in_ready_o(in_ready3),
    .out_valid_o(out_valid3), .out_data_o(out_data3), .out_ready_i(out_ready3),
`ifdef PIPE_BUF_STALL_CNT_EN
    .stall_cnt_o(stall3),
`endif
    .count_o(count3)
  );

  int checks = 0;
  int failures = 0;
  int phase = 0;
  int cyc = 0;
  int last_xfer2 = -1;
  int model_cnt = 0;
  bit started = 1'b0;
  bit done4 = 1'b0;
  logic [DW-1:0] exp2[$];
  logic [DW-1:0] exp3[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one item and hold it until the buffer takes it.
  task automatic send(input int sel, input logic [DW-1:0] d);
    int n = 0;
    if (sel == 2) begin in_valid2 = 1'b1; in_data2 = d; end
    else          begin in_valid3 = 1'b1; in_data3 = d; end
    @(negedge clk);
    while (((sel == 2) ? !in_ready2 : !in_ready3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL send_timeout dut=%0d data=%0h actual=not_accepted required=accepted", sel, d);
    end
    step();
    if (sel == 2) in_valid2 = 1'b0; else in_valid3 = 1'b0;
  endtask

  task automatic drain(input int sel);
    int n = 0;
    while (((sel == 2) ? exp2.size() : exp3.size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL drain_timeout dut=%0d actual=pending required=empty", sel);
    end
    step();
  endtask

  // DUT2 monitor: pops the scoreboard on every completed transfer.
  always @(negedge clk) begin
    if (started && rst && out_valid2 && out_ready2) begin
      if (exp2.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut2_unexpected actual=%0h required=none", out_data2);
      end else begin
        chk("dut2_data", 32'(out_data2), 32'(exp2.pop_front()));
      end
      if (phase == 2) begin
        chk("t2_count", 32'(count2), 32'd1);
        if (last_xfer2 >= 0) chk("t2_spacing", 32'(cyc - last_xfer2), 32'd1);
        last_xfer2 = cyc;
      end
    end
  end

  // DUT3 monitor: scoreboard plus an independent occupancy model during the wrap test.
  always @(negedge clk) begin
    if (started && rst) begin
      if (out_valid3 && out_ready3) begin
        if (exp3.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut3_unexpected actual=%0h required=none", out_data3);
        end else begin
          chk("dut3_data", 32'(out_data3), 32'(exp3.pop_front()));
        end
      end
      if (phase == 4) begin
        chk("t4_count", 32'(count3), 32'(model_cnt));
        chk("t4_in_ready", 32'(in_ready3), 32'(model_cnt != 3));
        chk("t4_out_valid", 32'(out_valid3), 32'(model_cnt != 0));
        model_cnt = model_cnt + ((in_valid3 && model_cnt != 3) ? 1 : 0)
                              - ((out_ready3 && model_cnt != 0) ? 1 : 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    flush2 = 1'b0; in_valid2 = 1'b1; in_data2 = 8'h5A; out_ready2 = 1'b0;
    flush3 = 1'b0; in_valid3 = 1'b1; in_data3 = 8'h5A; out_ready3 = 1'b0;

    // Reset held with input valid asserted.
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      chk("rst_count", 32'(count2), 32'd0);
      chk("rst_in_ready", 32'(in_ready2), 32'd1);
      chk("rst_out_valid", 32'(out_valid2), 32'd0);
      chk("rst_out_data", 32'(out_data2), 32'd0);
    end
    in_valid2 = 1'b0; in_valid3 = 1'b0;
    step();
    rst = 1'b1;
    started = 1'b1;
    @(negedge clk);
    chk("post_rst_count", 32'(count2), 32'd0);
    chk("post_rst_out_valid", 32'(out_valid2), 32'd0);
    chk("post_rst_count3", 32'(count3), 32'd0);
    step();

    // Streaming with downstream always ready.
    phase = 2;
    out_ready2 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp2.push_back(8'(i));
      send(2, 8'(i));
    end
    drain(2);
    phase = 0;

    // Backpressure to full, held offer, release.
    out_ready2 = 1'b0;
    exp2.push_back(8'h0A); send(2, 8'h0A);
    exp2.push_back(8'h0B); send(2, 8'h0B);
    @(negedge clk);
    chk("t3_full_count", 32'(count2), 32'd2);
    chk("t3_full_in_ready", 32'(in_ready2), 32'd0);
    chk("t3_head", 32'(out_data2), 32'h0A);
    step();
    in_valid2 = 1'b1; in_data2 = 8'h0C; exp2.push_back(8'h0C);
    @(negedge clk);
    chk("t3_held_count", 32'(count2), 32'd2);
    step();
    out_ready2 = 1'b1;
    @(negedge clk);
    chk("t3_pop_cycle_in_ready", 32'(in_ready2), 32'd0);
    step();
    @(negedge clk);
    chk("t3_after_pop_in_ready", 32'(in_ready2), 32'd1);
    chk("t3_after_pop_count", 32'(count2), 32'd1);
    step();
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("t3_pushpop_count", 32'(count2), 32'd1);
    drain(2);

    // Wrap on DEPTH=3 with pseudo-random downstream readiness.
    model_cnt = 0;
    done4 = 1'b0;
    phase = 4;
    fork
      begin
        for (int i = 1; i <= 10; i++) begin
          exp3.push_back(8'(i));
          send(3, 8'(i));
        end
        done4 = 1'b1;
      end
      begin
        int n = 0;
        while (!done4 && n < 300) begin
          out_ready3 = 1'($urandom_range(0, 1));
          step();
          n++;
        end
      end
    join
    out_ready3 = 1'b1;
    drain(3);
    phase = 0;

    // Flush from full with an offered item, then flush with a live same-cycle push.
    out_ready2 = 1'b0;
    send(2, 8'h11);
    send(2, 8'h22);
    @(negedge clk);
    chk("t5_pre_flush_count", 32'(count2), 32'd2);
    step();
    flush2 = 1'b1; in_valid2 = 1'b1; in_data2 = 8'h33;
    step();
    flush2 = 1'b0; in_valid2 = 1'b0;
    @(negedge clk);
    chk("t5_flush_count", 32'(count2), 32'd0);
    chk("t5_flush_out_valid", 32'(out_valid2), 32'd0);
    chk("t5_flush_in_ready", 32'(in_ready2), 32'd1);
    step();
    send(2, 8'h55);
    flush2 = 1'b1; in_valid2 = 1'b1; in_data2 = 8'h66;
    step();
    flush2 = 1'b0; in_valid2 = 1'b0;
    @(negedge clk);
    chk("t5_flush_push_count", 32'(count2), 32'd0);
    chk("t5_flush_push_out_valid", 32'(out_valid2), 32'd0);
    step();
    out_ready2 = 1'b1;
    exp2.push_back(8'h44);
    send(2, 8'h44);
    @(negedge clk);
    chk("t5_next_valid", 32'(out_valid2), 32'd1);
    chk("t5_next_data", 32'(out_data2), 32'h44);
    drain(2);

`ifdef PIPE_BUF_STALL_CNT_EN
    // Stall counter: five held cycles, survives flush, cleared by reset.
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_stall_reset", stall2, 32'd0);
    step();
    out_ready2 = 1'b0;
    exp2.push_back(8'h77);
    send(2, 8'h77);
    repeat (5) @(posedge clk);
    #1;
    out_ready2 = 1'b1;
    @(negedge clk);
    chk("t6_stall_five", stall2, 32'd5);
    step();
    @(negedge clk);
    chk("t6_stall_after_pop", stall2, 32'd5);
    step();
    flush2 = 1'b1;
    step();
    flush2 = 1'b0;
    @(negedge clk);
    chk("t6_stall_after_flush", stall2, 32'd5);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_stall_after_reset", stall2, 32'd0);
    step();
`endif

    chk("final_exp2_empty", 32'(exp2.size()), 32'd0);
    chk("final_exp3_empty", 32'(exp3.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic stage register between adjacent pipeline stages (IF->ID, ID->EX, ...), replacing the fixed single-entry stage latches. Carries an opaque payload bundle (pc, instr, prdt_taken, misalign, bus_err, ...) under a valid/ready handshake. Holds up to DEPTH entries, so a downstream stall no longer forces a combinational stall back to the upstream stage. Provides a synchronous flush for redirect and exception.

Parameters:
DATA_W, 70, payload width in bits (default covers 32b pc + 32b instr + flag bits).
DEPTH, 2, number of entries; legal range 1..16; DEPTH>=2 required for full throughput.
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-low.
flush_i  in  1  discard all entries and any same-cycle input.
in_valid_i  in  1  upstream payload valid.
in_data_i  in  DATA_W  upstream payload.
in_ready_o  out  1  buffer can accept; high when count_o != DEPTH.
out_valid_o  out  1  head entry valid; high when count_o != 0.
out_data_o  out  DATA_W  head entry payload.
out_ready_i  in  1  downstream accepts head this cycle.
count_o  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst==0 at clock edge): count=0, wr_ptr=0, rd_ptr=0. in_ready_o=1, out_valid_o=0, count_o=0. out_data_o=0 (storage cleared). Reset wins over every other input.
- push = in_valid_i & in_ready_o. pop = out_valid_o & out_ready_i.
- in_ready_o and out_valid_o are decoded from registered count only. There is no combinational path from out_ready_i to in_ready_o or from in_valid_i to out_valid_o.
- Latency: an entry pushed at edge N is visible on out_valid_o/out_data_o after edge N (one cycle); no bypass.
- Storage: circular array of DEPTH entries.
  - push writes mem[wr_ptr].
  - Each pointer wraps from DEPTH-1 to 0. DEPTH need not be a power of two.
- out_data_o = mem[rd_ptr]. Value is don't-care when out_valid_o=0, except after reset, when it reads 0.
- Count update:
  - push only: +1
  - pop only: -1
  - push & pop: unchanged, both pointers advance
  - neither: hold.
- Full (count==DEPTH): in_ready_o=0; a pop in this cycle does not enable a push in the same cycle. in_ready_o rises the cycle after the pop.
- Empty (count==0): out_valid_o=0; out_ready_i is ignored.
- DEPTH=1: behaves as a half-rate stage latch (max one transfer per 2 cycles).
- Flush (flush_i==1, rst==1): next state count=0, wr_ptr=rd_ptr=0.
  - A same-cycle push is dropped.
  - A same-cycle pop still counts as a completed transfer downstream; the buffer state is simply cleared.
  - Storage contents are not cleared.
  - in_ready_o=1 the cycle after a flush.
- in_valid_i while in_ready_o=0: no effect. The upstream stage must hold its data stable until it is accepted; the buffer does not check this.
- Ordering: strict FIFO; no entry is duplicated or lost except on flush or reset.

Optional Feature:
Macro PIPE_BUF_STALL_CNT_EN.
- Defined: adds output stall_cnt_o (32 bits).
  - Reset value 0.
  - Increments each cycle with out_valid_o & ~out_ready_i, saturating at 32'hFFFF_FFFF.
  - Not cleared by flush_i.
- Undefined: the port and its counter logic do not exist. All other behaviour is identical.

Test Plan:
1. Reset, DEPTH=2: hold rst=0 two cycles with in_valid_i=1 -> count_o=0, in_ready_o=1, out_valid_o=0, out_data_o=0 throughout; nothing stored.
2. Streaming, DEPTH=2: push 0x01..0x08 back-to-back with out_ready_i=1 constantly -> out_data_o sequence 0x01..0x08, one per cycle, starting one cycle after first push; count_o stays at 1.
3. Backpressure/full, DEPTH=2: push 0xA, 0xB with out_ready_i=0 -> count_o=2, in_ready_o=0; offer 0xC (held) -> not accepted. Raise out_ready_i -> pops 0xA; 0xC accepted the cycle after; order out is 0xA, 0xB, 0xC.
4. Wrap, DEPTH=3: 10 pushes interleaved with random out_ready_i -> output order 1..10 exact; pointers wrap 2->0 without loss; count_o never exceeds 3.
5. Flush: count_o=2 (0x11, 0x22), assert flush_i with in_valid_i=1 data 0x33 -> next cycle count_o=0, out_valid_o=0; 0x33 never appears on output; subsequent push 0x44 emerges next.
6. PIPE_BUF_STALL_CNT_EN defined: hold one entry with out_ready_i=0 for 5 cycles, then pop -> stall_cnt_o=5; flush afterwards -> stall_cnt_o still 5; reset -> 0.
